// File: rtl/gpu_pixel_pkg.sv
// Shared pixel types for the palette output stage: colour/coordinate widths,
// the packed {color, x, y} FIFO entry and a saturating counter helper.
package gpu_pixel_pkg;

  localparam int COLOR_W = 24;
  localparam int COORD_W = 11;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pixel_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pixel_fifo_ram.sv
// DEPTH x pixel_t storage: synchronous write port and a registered read port
// whose output holds until the next read enable.
module pixel_fifo_ram
  import gpu_pixel_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_pipe,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_t            rd_data
);

  pixel_t mem_q [DEPTH];
  pixel_t rd_data_q;

  // NOTE: the storage array carries no reset; only the pointers and count in
  // the top decide which entries are live, so clearing it would be wasted logic.
  always_ff @(posedge clk_pipe) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read of the slot being written in the same cycle returns the old entry.
  always_ff @(posedge clk_pipe) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/palette_pixel_fifo.sv
// Palette output FIFO: drops transparent and repeat-position pixels, buffers the
// rest, pops one per pixelReq. Optional PIXEL_FIFO_STATS_EN adds event counters.
module palette_pixel_fifo
  import gpu_pixel_pkg::*;
#(
  parameter int                 DEPTH             = 16,
  parameter int                 ALMOST_FULL_LEVEL = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR          = 24'h000000
) (
  input  logic                     clk_pipe,
  input  logic                     rst,
  input  logic                     pixelValid,
  input  logic                     pixelFound,
  input  logic [COLOR_W-1:0]       pixelColor,
  input  logic [COORD_W-1:0]       xPosition,
  input  logic [COORD_W-1:0]       yPosition,
  input  logic                     frameStart,
  input  logic                     pixelReq,
  output logic [COLOR_W-1:0]       pixelOut,
  output logic [COORD_W-1:0]       pixelOutX,
  output logic [COORD_W-1:0]       pixelOutY,
  output logic                     pixelOutValid,
  output logic                     underrun,
  output logic                     almostFull,
  output logic                     overflow,
`ifdef PIXEL_FIFO_STATS_EN
  output logic [15:0]              underrunCount,
  output logic [15:0]              dropCount,
`endif
  output logic [$clog2(DEPTH):0]   fifoCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [COORD_W-1:0] prev_x_q, prev_y_q;
  logic               have_prev_q;
  logic               out_valid_q, underrun_q, bg_sel_q, almost_full_q, overflow_q;

  logic   candidate, is_repeat, push_req, push, drop, pop, empty_req, full;
  pixel_t wr_entry, rd_entry;

  // frameStart masks the tracker combinationally so a coincident candidate
  // always compares against a cleared tracker.
  assign candidate = pixelValid & pixelFound;
  assign is_repeat = candidate & have_prev_q & ~frameStart
                   & (xPosition == prev_x_q) & (yPosition == prev_y_q);
  assign push_req  = candidate & ~is_repeat;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign pop       = pixelReq & (count_q != '0);
  assign empty_req = pixelReq & (count_q == '0);
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  assign wr_entry = '{color: pixelColor, x: xPosition, y: yPosition};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_pipe) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      prev_x_q      <= '0;
      prev_y_q      <= '0;
      have_prev_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      underrun_q    <= 1'b0;
      bg_sel_q      <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q       <= count_d;
      almost_full_q <= (count_d >= CNT_W'(ALMOST_FULL_LEVEL));
      out_valid_q   <= pixelReq;
      underrun_q    <= empty_req;
      if (pop)            bg_sel_q <= 1'b0;
      else if (empty_req) bg_sel_q <= 1'b1;
      if (drop) overflow_q <= 1'b1;
      // Dropped pixels still claim their position so lower layers stay hidden.
      if (push_req) begin
        prev_x_q    <= xPosition;
        prev_y_q    <= yPosition;
        have_prev_q <= 1'b1;
      end else if (frameStart) begin
        have_prev_q <= 1'b0;
      end
    end
  end

  pixel_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk_pipe (clk_pipe),
    .rst      (rst),
    .wr_en    (push),
    .wr_addr  (wr_ptr_q),
    .wr_data  (wr_entry),
    .rd_en    (pop),
    .rd_addr  (rd_ptr_q),
    .rd_data  (rd_entry)
  );

  assign pixelOut      = bg_sel_q ? BG_COLOR : rd_entry.color;
  assign pixelOutX     = rd_entry.x;
  assign pixelOutY     = rd_entry.y;
  assign pixelOutValid = out_valid_q;
  assign underrun      = underrun_q;
  assign almostFull    = almost_full_q;
  assign overflow      = overflow_q;
  assign fifoCount     = count_q;

`ifdef PIXEL_FIFO_STATS_EN
  logic [15:0] underrun_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_pipe) begin
    if (rst) begin
      underrun_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      if (empty_req) underrun_cnt_q <= sat_inc16(underrun_cnt_q);
      if (drop)      drop_cnt_q     <= sat_inc16(drop_cnt_q);
    end
  end

  assign underrunCount = underrun_cnt_q;
  assign dropCount     = drop_cnt_q;
`endif

endmodule
